add8_rr_share: RTL and testbench
================================

Name: add8_rr_share

Overview:
- Round-robin arbiter and sequencer that shares one combinational 8-bit adder (any add8_* netlist, A[7:0]/B[7:0] -> O[8:0]) among NREQ requesters.
- Operands are registered into a single issue stage that drives the external adder. The 9-bit result is captured into a per-requester response register.
- Throughput is one addition per cycle. Latency is 2 cycles from request handshake to response valid.

Parameters:
- NREQ, 4, number of requesters. Legal range 2..8.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, synchronous, active-high
- req_valid  input  NREQ  per-requester operand valid
- req_ready  output  NREQ  per-requester grant; at most one bit high
- req_a  input  8*NREQ  operand A; requester i uses bits [8i+7:8i]
- req_b  input  8*NREQ  operand B; same slicing as req_a
- add_a  output  8  registered operand to shared adder input A
- add_b  output  8  registered operand to shared adder input B
- add_o  input  9  shared adder output O[8:0], combinational from add_a/add_b
- rsp_valid  output  NREQ  per-requester result valid
- rsp_ready  input  NREQ  per-requester result accept
- rsp_sum  output  9*NREQ  result; requester i uses bits [9i+8:9i]
- busy  output  1  issue stage occupied
- op_count  output  CNT_W  completed operations, wrapping

Behaviour:
- Reset (rst high at an edge) has priority over all other activity:
  - stage_valid=0, add_a=0, add_b=0, stage_tag=0.
  - all rsp_valid=0, all rsp_sum=0.
  - rr pointer=0, op_count=0.
  - Any in-flight operation is discarded, with no response.
  - req_ready is 0 during any cycle in which rst is high.
- Eligibility: requester i is eligible when req_valid[i]=1 and rsp_valid[i]=0 and NOT (stage_valid=1 and stage_tag=i). At most one outstanding operation per requester.
- Arbitration (combinational, each cycle):
  - Scan requesters starting at pointer p, in order p, p+1, ..., NREQ-1, 0, ..., p-1.
  - The first eligible requester g gets req_ready[g]=1; all other bits are 0.
  - req_ready may depend combinationally on req_valid. Requesters must not gate req_valid on req_ready.
- Issue (edge where req_valid[g] & req_ready[g]):
  - add_a <= A slice of g; add_b <= B slice of g.
  - stage_tag <= g; stage_valid <= 1.
  - p <= (g+1) mod NREQ.
- No grant in a cycle: stage_valid <= 0, add_a/add_b hold their values, p holds.
- Retire (edge with stage_valid=1, tag t): rsp_sum[t] <= add_o; rsp_valid[t] <= 1; op_count <= op_count+1, wrapping at 2^CNT_W.
- Issue and retire in the same edge are legal, giving back-to-back throughput of one per cycle.
- Response: rsp_valid[i] clears on the edge where rsp_valid[i] & rsp_ready[i]. rsp_sum[i] holds until overwritten by the next retire for i.
  - A new retire for i cannot coincide with the clear, because requester i is ineligible while rsp_valid[i]=1.
- Timing: handshake at edge t -> adder sees operands during cycle t+1 -> rsp_valid high from edge t+2.
- Minimum requester-i reissue period is 3 cycles (handshake, retire, rsp handshake) when rsp_ready is held high.
- busy = stage_valid.
- Width: no truncation. rsp_sum is exactly the 9-bit adder output, approximate or exact. The block never corrects or checks the sum.

Test Plan:
- Single requester: rst for 2 cycles, then req0 A=8'h7F B=8'h01 with rsp_ready high and an exact adder model. Required: req_ready[0] high the same cycle; rsp_valid[0] two edges later with rsp_sum0=9'h080; op_count=1.
- All 4 requesters valid every cycle with rsp_ready high. Required: grants 0,1,2,3,0,1,... after the first response drains; no requester granted while rsp_valid or in stage; the 4 ops (10+20, 255+255, 0+0, 128+128) give 30, 510, 0, 256.
- Backpressure: rsp_ready[1]=0 with req1 valid continuously. Required: only one op for req1 completes, rsp_valid[1] stays high with a stable sum, req_ready[1] stays 0, other requesters still get served.
- Rotation fairness: from reset p=0, req2 and req3 valid. Required: req2 first, then req3, then req2 (pointer wraps).
- Reset mid-operation: assert rst on the edge after issuing req0 A=5 B=6. Required: rsp_valid stays 0, op_count=0, busy=0, add_a=add_b=0.
- Approximate adder plugged in (add_o driven by add8_108 model), A=8'd200 B=8'd100. Required: rsp_sum equals the model's output bit-exact, not 300.

Source files
------------

// File: rtl/add8_rr_share_if.sv
// Bus bundle between the requesters/external adder and the add8_rr_share sequencer.
// The slave modport is the sequencer; master is the requester and adder side.
interface add8_rr_share_if #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 16
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [7:0]        add_a;
    logic [7:0]        add_b;
    logic [8:0]        add_o;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [9*NREQ-1:0] rsp_sum;
    logic              busy;
    logic [CNT_W-1:0]  op_count;

    modport slave (
        input  req_valid, req_a, req_b, add_o, rsp_ready,
        output req_ready, add_a, add_b, rsp_valid, rsp_sum, busy, op_count
    );

    modport master (
        output req_valid, req_a, req_b, add_o, rsp_ready,
        input  req_ready, add_a, add_b, rsp_valid, rsp_sum, busy, op_count
    );
endinterface

// File: rtl/add8_rr_share.sv
// Round-robin sequencer sharing one external combinational 8-bit adder among NREQ
// requesters: one registered issue stage, per-requester 9-bit response registers.
module add8_rr_share #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    add8_rr_share_if.slave    bus
);
    localparam int TAG_W = $clog2(NREQ);

    logic              stage_valid_q, stage_valid_d;
    logic [7:0]        add_a_q, add_a_d;
    logic [7:0]        add_b_q, add_b_d;
    logic [TAG_W-1:0]  stage_tag_q, stage_tag_d;
    logic [TAG_W-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [9*NREQ-1:0] rsp_sum_q, rsp_sum_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;

    logic [NREQ-1:0]   eligible;
    logic [NREQ-1:0]   grant_oh;
    logic [TAG_W-1:0]  grant_idx;
    logic              grant_any;

    // A requester may have only one operation in flight: not in the stage, no pending response.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = bus.req_valid[i] && !rsp_valid_q[i]
                          && !(stage_valid_q && (stage_tag_q == TAG_W'(i)));
        end
    end

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_any && eligible[idx]) begin
                grant_any     = 1'b1;
                grant_idx     = TAG_W'(idx);
                grant_oh[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        stage_valid_d = 1'b0;
        add_a_d       = add_a_q;
        add_b_d       = add_b_q;
        stage_tag_d   = stage_tag_q;
        ptr_d         = ptr_q;
        rsp_valid_d   = rsp_valid_q & ~bus.rsp_ready;
        rsp_sum_d     = rsp_sum_q;
        op_count_d    = op_count_q;

        if (grant_any) begin
            stage_valid_d = 1'b1;
            add_a_d       = bus.req_a[8*int'(grant_idx) +: 8];
            add_b_d       = bus.req_b[8*int'(grant_idx) +: 8];
            stage_tag_d   = grant_idx;
            ptr_d         = (grant_idx == TAG_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;
        end

        // Retire cannot collide with a response clear for the same tag (eligibility forbids it).
        if (stage_valid_q) begin
            for (int i = 0; i < NREQ; i++) begin
                if (stage_tag_q == TAG_W'(i)) begin
                    rsp_valid_d[i]       = 1'b1;
                    rsp_sum_d[9*i +: 9]  = bus.add_o;
                end
            end
            op_count_d = op_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid_q <= 1'b0;
            add_a_q       <= '0;
            add_b_q       <= '0;
            stage_tag_q   <= '0;
            ptr_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_sum_q     <= '0;
            op_count_q    <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            add_a_q       <= add_a_d;
            add_b_q       <= add_b_d;
            stage_tag_q   <= stage_tag_d;
            ptr_q         <= ptr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_sum_q     <= rsp_sum_d;
            op_count_q    <= op_count_d;
        end
    end

    assign bus.req_ready = rst ? '0 : grant_oh;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.busy      = stage_valid_q;
    assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_add8_rr_share.sv
// Directed testbench for add8_rr_share with an exact or approximate adder model on add_o.
module tb_add8_rr_share;
    logic clk;
    logic rst;
    logic approxMode;
    int   nChecks;
    int   nFails;

    add8_rr_share_if #(.NREQ(4), .CNT_W(16)) bus ();

    add8_rr_share #(.NREQ(4), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Approximate model: upper six bits added exactly, two LSBs forced to 1.
    always_comb begin
        if (approxMode) begin
            bus.add_o = {1'b0, ({1'b0, bus.add_a[7:2]} + {1'b0, bus.add_b[7:2]}), 2'b11};
        end else begin
            bus.add_o = {1'b0, bus.add_a} + {1'b0, bus.add_b};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst           = 1'b1;
        bus.req_valid = '0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.req_valid = 4'b0001;
        bus.req_a     = 32'h0000_0011;
        bus.req_b     = 32'h0000_0022;
        bus.rsp_ready = 4'b1111;
        step();
        step();
        nChecks++;
        if (bus.req_ready !== 4'b0000) begin
            nFails++;
            $display("[TB] FAIL reset_req_ready got %b want 0000", bus.req_ready);
        end
        nChecks++;
        if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0000 || bus.op_count !== 16'd0) begin
            nFails++;
            $display("[TB] FAIL reset_state busy=%b rsp_valid=%b op_count=%0d want 0/0000/0",
                     bus.busy, bus.rsp_valid, bus.op_count);
        end
        nChecks++;
        if (bus.add_a !== 8'h00 || bus.add_b !== 8'h00 || bus.rsp_sum !== 36'h0) begin
            nFails++;
            $display("[TB] FAIL reset_data add_a=%h add_b=%h rsp_sum=%h want zeros",
                     bus.add_a, bus.add_b, bus.rsp_sum);
        end
        bus.req_valid = '0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        doReset();
        bus.req_a     = 32'h0000_007F;
        bus.req_b     = 32'h0000_0001;
        bus.rsp_ready = 4'b1111;
        bus.req_valid = 4'b0001;
        #1;
        nChecks++;
        if (bus.req_ready !== 4'b0001) begin
            nFails++;
            $display("[TB] FAIL single_grant got %b want 0001", bus.req_ready);
        end
        step();
        bus.req_valid = '0;
        #1;
        nChecks++;
        if (bus.busy !== 1'b1 || bus.add_a !== 8'h7F || bus.add_b !== 8'h01 || bus.rsp_valid !== 4'b0000) begin
            nFails++;
            $display("[TB] FAIL single_stage busy=%b a=%h b=%h rsp_valid=%b want 1/7f/01/0000",
                     bus.busy, bus.add_a, bus.add_b, bus.rsp_valid);
        end
        step();
        nChecks++;
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_sum[8:0] !== 9'h080 || bus.op_count !== 16'd1) begin
            nFails++;
            $display("[TB] FAIL single_rsp rsp_valid=%b sum0=%h op_count=%0d want 0001/080/1",
                     bus.rsp_valid, bus.rsp_sum[8:0], bus.op_count);
        end
        step();
        nChecks++;
        if (bus.rsp_valid !== 4'b0000 || bus.rsp_sum[8:0] !== 9'h080 || bus.busy !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL single_drain rsp_valid=%b sum0=%h busy=%b want 0000/080/0",
                     bus.rsp_valid, bus.rsp_sum[8:0], bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] expSum [4];
        expSum[0] = 9'd30;
        expSum[1] = 9'd510;
        expSum[2] = 9'd0;
        expSum[3] = 9'd256;
        doReset();
        bus.req_a     = {8'd128, 8'd0, 8'd255, 8'd10};
        bus.req_b     = {8'd128, 8'd0, 8'd255, 8'd20};
        bus.rsp_ready = 4'b1111;
        bus.req_valid = 4'b1111;
        #1;
        for (int c = 0; c < 8; c++) begin
            nChecks++;
            if (bus.req_ready !== (4'b0001 << (c % 4))) begin
                nFails++;
                $display("[TB] FAIL b2b_grant cycle %0d got %b want %b", c, bus.req_ready, 4'b0001 << (c % 4));
            end
            if (c >= 2) begin
                nChecks++;
                if (bus.rsp_valid[(c-2)%4] !== 1'b1 || bus.rsp_sum[9*((c-2)%4) +: 9] !== expSum[(c-2)%4]) begin
                    nFails++;
                    $display("[TB] FAIL b2b_rsp cycle %0d req %0d valid=%b sum=%0d want 1/%0d",
                             c, (c-2)%4, bus.rsp_valid[(c-2)%4], bus.rsp_sum[9*((c-2)%4) +: 9], expSum[(c-2)%4]);
                end
            end
            step();
        end
        nChecks++;
        if (bus.op_count !== 16'd7) begin
            nFails++;
            $display("[TB] FAIL b2b_count got %0d want 7", bus.op_count);
        end
        bus.req_valid = '0;
        step();
    endtask

    task automatic test_backpressure();
        int grants [4];
        for (int i = 0; i < 4; i++) grants[i] = 0;
        doReset();
        bus.req_a     = {8'd0, 8'd3, 8'h33, 8'd1};
        bus.req_b     = {8'd0, 8'd4, 8'h44, 8'd2};
        bus.rsp_ready = 4'b1101;
        bus.req_valid = 4'b0111;
        #1;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_ready[i]) grants[i]++;
            end
            if (c >= 3) begin
                nChecks++;
                if (bus.req_ready[1] !== 1'b0 || bus.rsp_valid[1] !== 1'b1 || bus.rsp_sum[17:9] !== 9'h077) begin
                    nFails++;
                    $display("[TB] FAIL bp_hold cycle %0d ready1=%b valid1=%b sum1=%h want 0/1/077",
                             c, bus.req_ready[1], bus.rsp_valid[1], bus.rsp_sum[17:9]);
                end
            end
            step();
        end
        nChecks++;
        if (grants[1] != 1) begin
            nFails++;
            $display("[TB] FAIL bp_req1_ops got %0d want 1", grants[1]);
        end
        nChecks++;
        if (grants[0] < 2 || grants[2] < 2) begin
            nFails++;
            $display("[TB] FAIL bp_others_served req0=%0d req2=%0d want >=2 each", grants[0], grants[2]);
        end
        bus.req_valid = '0;
        bus.rsp_ready = 4'b1111;
        step();
    endtask

    task automatic test_rotation();
        logic [3:0] expGrant [4];
        expGrant[0] = 4'b0100;
        expGrant[1] = 4'b1000;
        expGrant[2] = 4'b0000;
        expGrant[3] = 4'b0100;
        doReset();
        bus.req_a     = {8'd7, 8'd6, 8'd0, 8'd0};
        bus.req_b     = {8'd1, 8'd1, 8'd0, 8'd0};
        bus.rsp_ready = 4'b1111;
        bus.req_valid = 4'b1100;
        #1;
        for (int c = 0; c < 4; c++) begin
            nChecks++;
            if (bus.req_ready !== expGrant[c]) begin
                nFails++;
                $display("[TB] FAIL rotation cycle %0d got %b want %b", c, bus.req_ready, expGrant[c]);
            end
            step();
        end
        bus.req_valid = '0;
        step();
    endtask

    task automatic test_reset_mid();
        doReset();
        bus.req_a     = 32'h0000_0005;
        bus.req_b     = 32'h0000_0006;
        bus.rsp_ready = 4'b1111;
        bus.req_valid = 4'b0001;
        step();
        bus.req_valid = '0;
        rst = 1'b1;
        step();
        nChecks++;
        if (bus.rsp_valid !== 4'b0000 || bus.op_count !== 16'd0 || bus.busy !== 1'b0
            || bus.add_a !== 8'h00 || bus.add_b !== 8'h00) begin
            nFails++;
            $display("[TB] FAIL reset_mid valid=%b count=%0d busy=%b a=%h b=%h want all zero",
                     bus.rsp_valid, bus.op_count, bus.busy, bus.add_a, bus.add_b);
        end
        rst = 1'b0;
        step();
        step();
        nChecks++;
        if (bus.rsp_valid !== 4'b0000 || bus.op_count !== 16'd0) begin
            nFails++;
            $display("[TB] FAIL reset_mid_after valid=%b count=%0d want 0000/0", bus.rsp_valid, bus.op_count);
        end
    endtask

    task automatic test_approx();
        doReset();
        approxMode    = 1'b1;
        bus.req_a     = 32'h0000_00C8;
        bus.req_b     = 32'h0000_0064;
        bus.rsp_ready = 4'b1111;
        bus.req_valid = 4'b0001;
        step();
        bus.req_valid = '0;
        step();
        nChecks++;
        if (bus.rsp_valid[0] !== 1'b1 || bus.rsp_sum[8:0] !== 9'h12F) begin
            nFails++;
            $display("[TB] FAIL approx_sum valid=%b sum0=%h want 1/12f", bus.rsp_valid[0], bus.rsp_sum[8:0]);
        end
        approxMode = 1'b0;
        step();
    endtask

    initial begin
        nChecks       = 0;
        nFails        = 0;
        approxMode    = 1'b0;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_rotation();
        test_reset_mid();
        test_approx();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
